// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Latency: none (declarations only).
// Backpressure: n/a.
package imem_fetch_ctrl_pkg;

    localparam int          INSN_W  = 32;
    localparam int          FIFO_W  = 2 * INSN_W;   // {pc, insn}
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    // A PC may be fetched only if word aligned and inside the ROM; the
    // limit is 33 bits wide so a 4 GB ROM limit cannot wrap to zero.
    function automatic logic pc_legal(input logic [31:0] pc, input logic [32:0] limit);
        return (pc[1:0] == 2'b00) && ({1'b0, pc} < limit);
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_fifo.sv
// Synchronous prefetch FIFO holding {pc, insn} pairs; flush beats push and pop.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: o_full stalls the writer unless a pop frees the head slot the same edge.
module imem_fetch_ctrl_fifo
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = FIFO_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_wr_dat,
    output logic [W-1:0] o_rd_dat,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [W-1:0]  r_mem [DEPTH];

    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_wr_idx  = r_wr_ptr[AW-1:0];
    assign w_rd_idx  = r_rd_ptr[AW-1:0];
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_do_pop  = i_pop && !o_empty;
    // Writing into a full FIFO is safe when the head leaves on the same edge:
    // the slot being overwritten is the one being read out right now.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rd_dat  = r_mem[w_rd_idx];

    // Pointer update: flush empties the queue and discards any same-cycle push.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate validity.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[w_wr_idx] <= i_wr_dat;
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the ROM port, prefetches one word per cycle, hands {pc,insn} to decode.
// Latency: word read in cycle N appears on o_ins_out/o_ins_valid in cycle N+1.
// Backpressure: i_ins_ready low fills the prefetch FIFO, then ROM reads stop until decode pops.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          ROM_WORDS  = 128,
    parameter int          FIFO_DEPTH = 2,
    parameter int          CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    output logic [31:0]      o_iaddr,
    output logic             o_ins_mem_rw,
    input  logic [31:0]      i_idata_in,
    output logic             o_ins_valid,
    input  logic             i_ins_ready,
    output logic [31:0]      o_ins_out,
    output logic [31:0]      o_ins_pc,
    input  logic             i_redirect,
    input  logic [31:0]      i_redirect_pc,
    output logic             o_fetch_fault,
    output logic [CNT_W-1:0] o_fetch_count
);

    localparam logic [32:0]      ROM_BYTES = 33'(ROM_WORDS) * 33'd4;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    fetch_state_t     r_state;
    logic [31:0]      r_pc;
    logic             r_fault;
    logic [CNT_W-1:0] r_count;

    logic             w_pc_legal;
    logic             w_redir_legal;
    logic             w_pop;
    logic             w_issue;
    logic             w_full;
    logic             w_empty;
    logic [FIFO_W-1:0] w_head;

    assign w_pc_legal    = pc_legal(r_pc, ROM_BYTES);
    assign w_redir_legal = pc_legal(i_redirect_pc, ROM_BYTES);
    assign w_pop         = o_ins_valid && i_ins_ready;

    // Enable is in the issue term so that dropping it stops the read in the
    // same cycle rather than one cycle later when the FSM reaches IDLE.
    assign w_issue = (r_state == ST_FETCH) && i_enable && !i_redirect &&
                     w_pc_legal && (!w_full || w_pop);

    assign o_iaddr       = r_pc;
    assign o_ins_mem_rw  = w_issue;
    assign o_ins_valid   = !w_empty;
    assign o_ins_pc      = w_head[FIFO_W-1:INSN_W];
    assign o_ins_out     = w_head[INSN_W-1:0];
    assign o_fetch_fault = r_fault;
    assign o_fetch_count = r_count;

    imem_fetch_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FIFO_W)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_push   (w_issue),
        .i_pop    (w_pop),
        .i_flush  (i_redirect),
        .i_wr_dat ({r_pc, i_idata_in}),
        .o_rd_dat (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    // Fetch FSM with PC, sticky fault flag and saturating push counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
            r_count <= '0;
        end else if (i_redirect) begin
            // Redirect overrides everything, including an active fault.
            r_pc <= i_redirect_pc;
            if (w_redir_legal) begin
                r_fault <= 1'b0;
                r_state <= i_enable ? ST_FETCH : ST_IDLE;
            end else begin
                r_fault <= 1'b1;
                r_state <= ST_FAULT;
            end
        end else begin
            if (w_issue) begin
                r_pc <= r_pc + PC_STEP;
                if (r_count != CNT_MAX) r_count <= r_count + CNT_ONE;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_enable) r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    // Range check happens before the increment can wrap.
                    if (!w_pc_legal) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                    end else if (!i_enable) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_enable = 1'b0;
    logic [31:0] o_iaddr;
    logic        o_ins_mem_rw;
    logic [31:0] i_idata_in;
    logic        o_ins_valid;
    logic        i_ins_ready = 1'b0;
    logic [31:0] o_ins_out;
    logic [31:0] o_ins_pc;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;
    logic        o_fetch_fault;
    logic [2:0]  o_fetch_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] delivered [$];

    always #5 i_clk = ~i_clk;

    // ROM model: word i holds value i, combinational from the address.
    assign i_idata_in = {2'b00, o_iaddr[31:2]};

    imem_fetch_ctrl #(
        .RESET_PC   (32'h0),
        .ROM_WORDS  (128),
        .FIFO_DEPTH (2),
        .CNT_W      (3)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
        .o_iaddr       (o_iaddr),
        .o_ins_mem_rw  (o_ins_mem_rw),
        .i_idata_in    (i_idata_in),
        .o_ins_valid   (o_ins_valid),
        .i_ins_ready   (i_ins_ready),
        .o_ins_out     (o_ins_out),
        .o_ins_pc      (o_ins_pc),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_fetch_fault (o_fetch_fault),
        .o_fetch_count (o_fetch_count)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, let them settle, and
    // log any handshake that will complete on the coming rising edge.
    task automatic cyc(input logic en, input logic rdy, input logic redir, input logic [31:0] rpc);
        @(negedge i_clk);
        i_enable      = en;
        i_ins_ready   = rdy;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        #1;
        if (o_ins_valid && i_ins_ready) delivered.push_back({o_ins_pc, o_ins_out});
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        i_enable = 1'b0;
        i_ins_ready = 1'b0;
        i_redirect = 1'b0;
        i_redirect_pc = 32'h0;
        @(negedge i_clk);
        i_rst = 1'b0;
        delivered.delete();
    endtask

    initial begin
        int n;
        // ---- reset state ----
        #12;
        chk("rst_iaddr", o_iaddr, 0);
        chk("rst_rw", o_ins_mem_rw, 0);
        chk("rst_valid", o_ins_valid, 0);
        chk("rst_fault", o_fetch_fault, 0);
        chk("rst_count", o_fetch_count, 0);
        do_reset();

        // ---- test 1: sequential fetch ----
        cyc(1, 1, 0, 0);
        chk("t1_idle_rw", o_ins_mem_rw, 0);
        cyc(1, 1, 0, 0);
        chk("t1_rw0", o_ins_mem_rw, 1);
        chk("t1_addr0", o_iaddr, 32'h0);
        chk("t1_valid0", o_ins_valid, 0);
        cyc(1, 1, 0, 0);
        chk("t1_addr4", o_iaddr, 32'h4);
        chk("t1_ins0", {o_ins_valid, o_ins_out}, {1'b1, 32'd0});
        cyc(1, 1, 0, 0);
        chk("t1_ins1", {o_ins_valid, o_ins_out}, {1'b1, 32'd1});
        cyc(1, 1, 0, 0);
        chk("t1_ins2", {o_ins_valid, o_ins_out}, {1'b1, 32'd2});
        chk("t1_count", o_fetch_count, 3);

        // ---- test 2: decode stall fills FIFO, then resumes ----
        cyc(1, 0, 0, 0);
        chk("t2_first_rw", o_ins_mem_rw, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0);
            chk("t2_full_rw", o_ins_mem_rw, 0);
            chk("t2_hold_pc", {o_ins_valid, o_ins_pc}, {1'b1, 32'hC});
        end
        cyc(1, 1, 0, 0);
        chk("t2_push_on_pop", o_ins_mem_rw, 1);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0);
        chk("t2_deliv_n", delivered.size(), 9);
        for (int i = 0; i < delivered.size() && i < 9; i++)
            chk("t2_seq", delivered[i], {32'(i * 4), 32'(i)});

        // ---- test 3: redirect flushes 0x8/0xC ----
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("t3_full_rw", o_ins_mem_rw, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 32'h40);
        chk("t3_head8", o_ins_pc, 32'h8);
        chk("t3_redir_rw", o_ins_mem_rw, 0);
        cyc(1, 1, 0, 0);
        chk("t3_flushed", o_ins_valid, 0);
        chk("t3_addr40", {o_ins_mem_rw, o_iaddr}, {1'b1, 32'h40});
        cyc(1, 1, 0, 0);
        chk("t3_head40", {o_ins_valid, o_ins_pc, o_ins_out}, {1'b1, 32'h40, 32'h10});
        chk("t3_deliv_n", delivered.size(), 3);
        if (delivered.size() == 3) begin
            chk("t3_d0", delivered[0][63:32], 32'h0);
            chk("t3_d1", delivered[1][63:32], 32'h4);
            chk("t3_d2", delivered[2][63:32], 32'h40);
        end

        // ---- test 4: run off the end of the ROM ----
        delivered.delete();
        n = 0;
        while (!o_fetch_fault && n < 300) begin
            cyc(1, 1, 0, 0);
            n++;
        end
        chk("t4_fault", o_fetch_fault, 1);
        chk("t4_rw", o_ins_mem_rw, 0);
        chk("t4_addr", o_iaddr, 32'h200);
        chk("t4_valid", o_ins_valid, 0);
        chk("t4_count_sat", o_fetch_count, 3'd7);
        if (delivered.size() >= 2) begin
            chk("t4_last", delivered[delivered.size()-1], {32'h1FC, 32'h7F});
            chk("t4_prev", delivered[delivered.size()-2], {32'h1F8, 32'h7E});
        end else begin
            chk("t4_deliv_n", delivered.size(), 2);
        end
        cyc(1, 1, 0, 0);
        chk("t4_sticky", {o_fetch_fault, o_ins_mem_rw}, {1'b1, 1'b0});

        // ---- test 5: illegal redirect, redirect with same-cycle pop ----
        delivered.delete();
        cyc(1, 1, 1, 32'h0);
        cyc(1, 1, 0, 0);
        chk("t5_cleared", o_fetch_fault, 0);
        chk("t5_rw0", {o_ins_mem_rw, o_iaddr}, {1'b1, 32'h0});
        cyc(1, 1, 1, 32'h6);
        chk("t5_pop_head", {o_ins_valid, o_ins_pc}, {1'b1, 32'h0});
        chk("t5_redir_rw", o_ins_mem_rw, 0);
        cyc(1, 1, 0, 0);
        chk("t5_fault", o_fetch_fault, 1);
        chk("t5_norw", o_ins_mem_rw, 0);
        chk("t5_addr6", o_iaddr, 32'h6);
        chk("t5_valid", o_ins_valid, 0);
        cyc(1, 1, 0, 0);
        chk("t5_norw2", o_ins_mem_rw, 0);
        cyc(1, 1, 1, 32'h10);
        cyc(1, 1, 0, 0);
        chk("t5_restart", {o_fetch_fault, o_ins_valid, o_ins_mem_rw, o_iaddr}, {1'b0, 1'b0, 1'b1, 32'h10});
        cyc(1, 1, 0, 0);
        chk("t5_head10", o_ins_pc, 32'h10);
        cyc(0, 1, 0, 0);
        chk("t5_en_gate", o_ins_mem_rw, 0);
        chk("t5_deliv_n", delivered.size(), 3);
        if (delivered.size() == 3) begin
            chk("t5_d0", delivered[0][63:32], 32'h0);
            chk("t5_d1", delivered[1][63:32], 32'h10);
            chk("t5_d2", delivered[2][63:32], 32'h14);
        end

        // ---- test 6: asynchronous reset with a full FIFO ----
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        @(negedge i_clk);
        #1;
        chk("t6_pre_valid", o_ins_valid, 1);
        chk("t6_pre_addr", o_iaddr, 32'h8);
        i_rst = 1'b1;
        #1;
        chk("t6_valid", o_ins_valid, 0);
        chk("t6_addr", o_iaddr, 32'h0);
        chk("t6_rw", o_ins_mem_rw, 0);
        chk("t6_count", o_fetch_count, 0);
        @(negedge i_clk);
        i_rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
